// File: rtl/debug_tx_serializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : debug_tx_serializer_if                                         |
// | Purpose   : Groups the FIFO-pop and UART-TX handshake of the debug TX      |
// |             serializer into one bundle.                                    |
// | Signals   : i_fifo_empty / i_fifo_data / o_fifo_rd : TX FIFO side          |
// |             o_tx_start / o_tx_data / i_tx_done     : UART transmitter side |
// |             o_busy / o_words_sent                  : status                |
// | Modports  : slave  - serializer view (i_* in, o_* out)                     |
// |             master - environment view (drives i_*, observes o_*)           |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface debug_tx_serializer_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
);
  logic                   i_fifo_empty;
  logic [DATA_WIDTH-1:0]  i_fifo_data;
  logic                   o_fifo_rd;
  logic                   o_tx_start;
  logic [7:0]             o_tx_data;
  logic                   i_tx_done;
  logic                   o_busy;
  logic [COUNT_WIDTH-1:0] o_words_sent;

  modport slave (
    input  i_fifo_empty, i_fifo_data, i_tx_done,
    output o_fifo_rd, o_tx_start, o_tx_data, o_busy, o_words_sent
  );

  modport master (
    output i_fifo_empty, i_fifo_data, i_tx_done,
    input  o_fifo_rd, o_tx_start, o_tx_data, o_busy, o_words_sent
  );
endinterface
`default_nettype wire

// File: rtl/debug_tx_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : debug_tx_serializer                                             |
// | Purpose  : Pops DATA_WIDTH-bit words from the debug TX FIFO and hands them |
// |            to a byte-wide UART transmitter, least significant byte first,  |
// |            counting fully transmitted words (saturating).                  |
// | Ports    : i_clk   - clock, rising edge                                    |
// |            i_reset - asynchronous, active-low reset                        |
// |            bus     - debug_tx_serializer_if.slave (FIFO, UART, status)     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module debug_tx_serializer #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  wire logic               i_clk,
  input  wire logic               i_reset,
  debug_tx_serializer_if.slave    bus
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(BYTES - 1);

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_POP  = 2'd1;
  localparam logic [1:0] c_S_SEND = 2'd2;
  localparam logic [1:0] c_S_WAIT = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [IDX_W-1:0]       idx_q,   idx_d;
  logic [COUNT_WIDTH-1:0] words_q, words_d;
  // Low for the first edge after reset release so the first pop cannot
  // happen before the second rising edge.
  logic                   arm_q;

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= c_S_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      words_q <= '0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      words_q <= words_d;
      arm_q   <= 1'b1;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    words_d = words_q;
    case (state_q)
      c_S_IDLE: begin
        if (arm_q && !bus.i_fifo_empty) state_d = c_S_POP;
      end
      c_S_POP: begin
        shift_d = bus.i_fifo_data;
        idx_d   = '0;
        state_d = c_S_SEND;
      end
      c_S_SEND: begin
        state_d = c_S_WAIT;
      end
      c_S_WAIT: begin
        if (bus.i_tx_done) begin
          if (idx_q != c_LAST_IDX) begin
            shift_d = shift_q >> 8;
            idx_d   = idx_q + IDX_W'(1);
            state_d = c_S_SEND;
          end else begin
            if (words_q != '1) words_d = words_q + COUNT_WIDTH'(1);
            // Chain straight into the next pop when more data is waiting.
            state_d = bus.i_fifo_empty ? c_S_IDLE : c_S_POP;
          end
        end
      end
      default: state_d = c_S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state only
  always_comb begin
    bus.o_fifo_rd    = (state_q == c_S_POP);
    bus.o_tx_start   = (state_q == c_S_SEND);
    bus.o_busy       = (state_q != c_S_IDLE);
    bus.o_tx_data    = shift_q[7:0];
    bus.o_words_sent = words_q;
  end

endmodule
`default_nettype wire

// File: doc/debug_tx_serializer.md
DEBUG_TX_SERIALIZER -- requirements
Module: debug_tx_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of one word popped from the debug TX FIFO; SHALL be a multiple of 8.
REQ-002 Parameter COUNT_WIDTH, default 16, width of the sent-word counter.
REQ-003 i_clk  input  1  single clock; all state changes on rising edge.
REQ-004 i_reset  input  1  reset, asynchronous, active-low.
REQ-005 i_fifo_empty  input  1  high when the TX FIFO holds no word.
REQ-006 i_fifo_data  input  DATA_WIDTH  FIFO read data, valid during the cycle o_fifo_rd is high.
REQ-007 o_fifo_rd  output  1  one-cycle pop request to the FIFO.
REQ-008 o_tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-009 o_tx_data  output  8  byte presented to the UART transmitter.
REQ-010 i_tx_done  input  1  one-cycle pulse from the UART transmitter when the current byte has left the line.
REQ-011 o_busy  output  1  high in every state except IDLE.
REQ-012 o_words_sent  output  COUNT_WIDTH  number of words fully transmitted since reset.

Function
REQ-013 FSM states: IDLE, POP, SEND, WAIT; state SHALL be registered.
REQ-014 IDLE: o_busy=0; if i_fifo_empty=0 -> POP next cycle; else stay.
REQ-015 POP: o_fifo_rd=1 for exactly this cycle; at its closing edge, i_fifo_data captured into shift register, byte index cleared to 0; -> SEND.
REQ-016 SEND: o_tx_start=1 for exactly this cycle; o_tx_data = shift register bits [7:0]; -> WAIT.
REQ-017 WAIT: hold o_tx_data stable; o_tx_start=0; remain until i_tx_done=1.
REQ-018 WAIT with i_tx_done=1 and byte index < DATA_WIDTH/8-1: shift register shifted right 8 bits, byte index incremented; -> SEND.
REQ-019 WAIT with i_tx_done=1 and byte index = DATA_WIDTH/8-1: o_words_sent incremented; -> POP if i_fifo_empty=0, else -> IDLE.
REQ-020 Byte order: least significant byte first (bits [7:0], then [15:8], ...).
REQ-021 Latency: i_fifo_empty falls while IDLE in cycle N -> o_fifo_rd in N+1 -> o_tx_start in N+2.
REQ-022 Back-to-back words: i_tx_done on last byte in cycle M with FIFO non-empty -> o_fifo_rd in M+1, no IDLE cycle.
REQ-023 i_tx_done in IDLE, POP or SEND SHALL be ignored.
REQ-024 o_fifo_rd SHALL never assert while i_fifo_empty=1; o_fifo_rd and o_tx_start SHALL never assert in the same cycle.
REQ-025 o_words_sent SHALL saturate at all-ones (no wrap).
REQ-026 i_fifo_empty rising during POP/SEND/WAIT SHALL not affect the word in progress.

Reset
REQ-027 i_reset low SHALL immediately, without a clock edge, force: state IDLE, o_fifo_rd=0, o_tx_start=0, o_tx_data=8'h00, o_busy=0, o_words_sent=0, shift register and byte index 0.
REQ-028 Reset mid-word SHALL abandon remaining bytes; the partial word SHALL not be counted and no further o_tx_start SHALL occur until a new POP.
REQ-029 After i_reset rises, first o_fifo_rd no earlier than the second rising edge.

Verification
REQ-030 Single word: FIFO supplies 32'hA1B2C3D4, tx_done returned 10 cycles after each start -> o_tx_data sequence D4, C3, B2, A1, exactly 4 o_tx_start pulses, one o_fifo_rd, o_words_sent=1, return to IDLE with o_busy=0.
REQ-031 Back-to-back: FIFO holds 32'h00000001 then 32'hFFFFFFFF -> bytes 01,00,00,00,FF,FF,FF,FF; second o_fifo_rd exactly 1 cycle after 4th i_tx_done; o_words_sent=2.
REQ-032 Spurious done: pulse i_tx_done in IDLE and in SEND -> no state change, no extra start, byte index unchanged.
REQ-033 Async reset mid-word: assert i_reset low between 2nd start and 2nd done -> outputs reset values within the same cycle, o_words_sent=0, no further starts while FIFO empty.
REQ-034 Empty FIFO: i_fifo_empty held 1 for 100 cycles -> o_fifo_rd and o_tx_start never assert, o_busy=0.
REQ-035 Saturation: COUNT_WIDTH=2, send 5 words -> o_words_sent reads 1,2,3,3,3.
